// File: rtl/classification_ctrl_pkg.sv
// Shared k-means definitions: controller state encoding and pipeline latency defaults.
package classification_ctrl_pkg;

    // Controller pass phases.
    typedef enum logic [2:0] {
        StIdle,
        StLoadCen,
        StStream,
        StDrain,
        StDone
    } state_e;

    // RAM read latency (read strobe to data valid).
    localparam int unsigned RD_LAT_DEFAULT  = 1;
    // Input-register load to accumulator capture of the same point.
    localparam int unsigned ACC_LAT_DEFAULT = 3;

endpackage

// File: rtl/valid_delay_line.sv
// Never-stalled valid shift register; every stage is visible as a tap.
module valid_delay_line #(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic [DEPTH-1:0] o_taps
);

    logic [DEPTH-1:0] r_sr;

    // Shift one stage per clock; tap i is i_valid delayed by i+1 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_valid;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_taps = r_sr;

endmodule

// File: rtl/classification_ctrl.sv
// Classification pass controller: loads centroids, streams points from RAM and
// tracks in-flight points through the read and accumulate pipeline.
module classification_ctrl
    import classification_ctrl_pkg::*;
#(
    parameter int unsigned addrWidth    = 8,
    parameter int unsigned centroid_num = 8,
    parameter int unsigned RD_LAT       = RD_LAT_DEFAULT,
    parameter int unsigned ACC_LAT      = ACC_LAT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [addrWidth-1:0]    i_num_points,
    input  logic [3:0]              i_k,
    input  logic                    i_hold,
    output logic [addrWidth-1:0]    o_ram_addr,
    output logic                    o_ram_rd_en,
    output logic                    o_ram_input_reg_en,
    output logic [centroid_num-1:0] o_centroid_en,
    output logic                    o_accum_clr,
    output logic                    o_accumulators_en,
    output logic                    o_busy,
    output logic                    o_done
);

    // Both latencies are assumed to be at least one cycle.
    localparam int unsigned DelayDepth = RD_LAT + ACC_LAT;

    state_e                  r_state;
    // Issued-point count; its low bits double as the read address.
    logic [addrWidth:0]      r_issued;
    logic [addrWidth-1:0]    r_num_points;
    logic [addrWidth-1:0]    r_last_addr;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_accum_clr;
    logic [centroid_num-1:0] r_centroid_en;

    logic                    w_rd_en;
    logic [addrWidth-1:0]    w_cur_addr;
    logic                    w_last_issue;
    logic [DelayDepth-1:0]   w_taps;
    logic                    w_drain_empty;
    logic [centroid_num-1:0] w_cen_mask;

    assign w_rd_en      = (r_state == StStream) && !i_hold;
    assign w_cur_addr   = r_issued[addrWidth-1:0];
    assign w_last_issue = w_rd_en && (r_issued == {1'b0, r_num_points});
    // Only the final stage still holds a point, so the line is empty after this edge.
    assign w_drain_empty = (w_taps[DelayDepth-2:0] == '0);

    // Centroid load mask: k out of range (0 or above the register count) loads all.
    always_comb begin
        w_cen_mask = '0;
        for (int i = 0; i < int'(centroid_num); i++) begin
            if (i_k == 4'd0 || int'(i_k) > int'(centroid_num)) begin
                w_cen_mask[i] = 1'b1;
            end else begin
                w_cen_mask[i] = (i < int'(i_k));
            end
        end
    end

    // Pass sequencing FSM with registered state-decoded outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_issued      <= '0;
            r_num_points  <= '0;
            r_last_addr   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_accum_clr   <= 1'b0;
            r_centroid_en <= '0;
        end else begin
            r_done        <= 1'b0;
            r_accum_clr   <= 1'b0;
            r_centroid_en <= '0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state       <= StLoadCen;
                        r_num_points  <= i_num_points;
                        r_busy        <= 1'b1;
                        r_accum_clr   <= 1'b1;
                        r_centroid_en <= w_cen_mask;
                    end
                end
                StLoadCen: begin
                    r_state  <= StStream;
                    r_issued <= '0;
                end
                StStream: begin
                    if (w_rd_en) begin
                        r_issued    <= r_issued + {{addrWidth{1'b0}}, 1'b1};
                        r_last_addr <= w_cur_addr;
                    end
                    if (w_last_issue) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (w_drain_empty) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    valid_delay_line #(
        .DEPTH (DelayDepth)
    ) u_valid_delay_line (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_rd_en),
        .o_taps  (w_taps)
    );

    assign o_ram_rd_en        = w_rd_en;
    // Address stays on the last issued point while no read is strobed.
    assign o_ram_addr         = w_rd_en ? w_cur_addr : r_last_addr;
    assign o_ram_input_reg_en = w_taps[RD_LAT-1];
    assign o_accumulators_en  = w_taps[DelayDepth-1];
    assign o_centroid_en      = r_centroid_en;
    assign o_accum_clr        = r_accum_clr;
    assign o_busy             = r_busy;
    assign o_done             = r_done;

endmodule

// File: tb/tb_classification_ctrl.sv
// Self-checking bench for classification_ctrl against a timeline model of each pass.
module tb_classification_ctrl;

    localparam int AW  = 8;
    localparam int CN  = 8;
    localparam int RD  = 1;
    localparam int ACC = 3;
    localparam int MAXT = 1024;

    logic          clk;
    logic          rst;
    logic          i_start;
    logic [AW-1:0] i_num_points;
    logic [3:0]    i_k;
    logic          i_hold;
    logic [AW-1:0] o_ram_addr;
    logic          o_ram_rd_en;
    logic          o_ram_input_reg_en;
    logic [CN-1:0] o_centroid_en;
    logic          o_accum_clr;
    logic          o_accumulators_en;
    logic          o_busy;
    logic          o_done;

    int n_cmp = 0;
    int n_err = 0;

    // Expected per-cycle timeline of one pass.
    bit       h     [MAXT];
    bit       e_rd  [MAXT];
    int       a_at  [MAXT];
    int       e_addr[MAXT];
    bit       e_ire [MAXT];
    bit       e_acc [MAXT];
    bit       e_done[MAXT];
    bit       e_busy[MAXT];
    bit       e_clr [MAXT];
    logic [7:0] e_cen[MAXT];
    int       model_last_addr = 0;

    classification_ctrl #(
        .addrWidth    (AW),
        .centroid_num (CN),
        .RD_LAT       (RD),
        .ACC_LAT      (ACC)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_start            (i_start),
        .i_num_points       (i_num_points),
        .i_k                (i_k),
        .i_hold             (i_hold),
        .o_ram_addr         (o_ram_addr),
        .o_ram_rd_en        (o_ram_rd_en),
        .o_ram_input_reg_en (o_ram_input_reg_en),
        .o_centroid_en      (o_centroid_en),
        .o_accum_clr        (o_accum_clr),
        .o_accumulators_en  (o_accumulators_en),
        .o_busy             (o_busy),
        .o_done             (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int t, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [7:0] cen_mask(input int kk);
        if (kk == 0 || kk > CN) return 8'hFF;
        return 8'((1 << kk) - 1);
    endfunction

    task automatic check_all_zero(input string tag, input int t);
        chk({tag, ".rd"},   t, 32'(o_ram_rd_en), 0);
        chk({tag, ".addr"}, t, 32'(o_ram_addr), 0);
        chk({tag, ".ire"},  t, 32'(o_ram_input_reg_en), 0);
        chk({tag, ".acc"},  t, 32'(o_accumulators_en), 0);
        chk({tag, ".cen"},  t, 32'(o_centroid_en), 0);
        chk({tag, ".clr"},  t, 32'(o_accum_clr), 0);
        chk({tag, ".busy"}, t, 32'(o_busy), 0);
        chk({tag, ".done"}, t, 32'(o_done), 0);
    endtask

    // One pass: start at t=0; optional forced hold cycle, extra start pulse, reset cycle.
    task automatic run_pass(input string tag, input int n, input int kk, input int hold_pct,
                            input int force_hold_t, input int start_mid, input int rst_at);
        int issued;
        int last;
        int t;
        int done_t;
        int len;
        int cur;
        int nrd;
        int ndone;
        for (int i = 0; i < MAXT; i++) begin
            h[i]      = (hold_pct > 0) ? ($urandom_range(99) < hold_pct) : 1'b0;
            e_rd[i]   = 0;
            a_at[i]   = 0;
            e_ire[i]  = 0;
            e_acc[i]  = 0;
            e_done[i] = 0;
            e_busy[i] = 0;
            e_clr[i]  = 0;
            e_cen[i]  = 8'h00;
        end
        if (force_hold_t >= 0) h[force_hold_t] = 1'b1;
        e_clr[1] = 1;
        e_cen[1] = cen_mask(kk);
        issued = 0;
        last = 2;
        t = 2;
        while (issued <= n && t < MAXT - 16) begin
            if (!h[t]) begin
                e_rd[t] = 1;
                a_at[t] = issued;
                issued++;
                last = t;
            end
            t++;
        end
        for (int r = 2; r <= last; r++) begin
            if (e_rd[r]) begin
                e_ire[r + RD]       = 1;
                e_acc[r + RD + ACC] = 1;
            end
        end
        done_t = last + RD + ACC + 1;
        e_done[done_t] = 1;
        for (int i = 1; i <= done_t; i++) e_busy[i] = 1;
        len = done_t + 3;
        if (rst_at >= 0) begin
            for (int i = rst_at; i < MAXT; i++) begin
                e_rd[i] = 0; e_ire[i] = 0; e_acc[i] = 0; e_done[i] = 0;
                e_busy[i] = 0; e_clr[i] = 0; e_cen[i] = 8'h00;
            end
            len = rst_at + 1;
        end
        cur = model_last_addr;
        for (int i = 0; i < len; i++) begin
            if (i == rst_at) cur = 0;
            if (e_rd[i]) cur = a_at[i];
            e_addr[i] = cur;
        end
        model_last_addr = cur;

        nrd = 0;
        ndone = 0;
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            rst          = (i == rst_at);
            i_start      = (i == 0) || (i == start_mid);
            i_hold       = h[i];
            i_num_points = (i == 0) ? AW'(n) : AW'($urandom);
            i_k          = (i == 0) ? 4'(kk) : 4'($urandom);
            @(negedge clk);
            chk({tag, ".rd"},   i, 32'(o_ram_rd_en), 32'(e_rd[i]));
            chk({tag, ".addr"}, i, 32'(o_ram_addr), 32'(e_addr[i]));
            chk({tag, ".ire"},  i, 32'(o_ram_input_reg_en), 32'(e_ire[i]));
            chk({tag, ".acc"},  i, 32'(o_accumulators_en), 32'(e_acc[i]));
            chk({tag, ".done"}, i, 32'(o_done), 32'(e_done[i]));
            chk({tag, ".busy"}, i, 32'(o_busy), 32'(e_busy[i]));
            chk({tag, ".clr"},  i, 32'(o_accum_clr), 32'(e_clr[i]));
            chk({tag, ".cen"},  i, 32'(o_centroid_en), 32'(e_cen[i]));
            nrd   += int'(o_ram_rd_en);
            ndone += int'(o_done);
        end
        if (rst_at < 0) begin
            chk({tag, ".nreads"}, len, 32'(nrd), 32'(n + 1));
            chk({tag, ".ndone"},  len, 32'(ndone), 1);
        end
    endtask

    initial begin
        rst          = 1'b1;
        i_start      = 1'b0;
        i_num_points = '0;
        i_k          = '0;
        i_hold       = 1'b0;
        #3;
        check_all_zero("reset", 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_hold", 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset", 2);

        run_pass("basic",      3,  8, 0, -1, -1, -1);
        run_pass("hold3",      3,  8, 0,  3, -1, -1);
        run_pass("k3",         5,  3, 0, -1, -1, -1);
        run_pass("k0",         2,  0, 0, -1, -1, -1);
        run_pass("k12",        1, 12, 0, -1, -1, -1);
        run_pass("n0",         0,  5, 0, -1, -1, -1);
        run_pass("n0_hold",    0,  1, 50, 2, -1, -1);
        run_pass("full",     255,  8, 20, -1, -1, -1);
        // Reset in cycle 4, then restart on the very next cycle.
        run_pass("rst_mid",    3,  8, 0, -1, -1,  4);
        run_pass("after_rst",  3,  8, 0, -1, -1, -1);
        run_pass("rst_hold",  20,  4, 30, -1, -1, 7);
        run_pass("after_rst2", 6,  2, 30, -1, -1, -1);
        run_pass("start_mid", 10,  8, 30, -1,  4, -1);
        for (int p = 0; p < 6; p++) begin
            run_pass("rand", int'($urandom_range(40)), int'($urandom_range(15)), 25,
                     -1, int'($urandom_range(3, 6)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/classification_ctrl.md
CLASSIFICATION_CTRL -- requirements
Module: classification_ctrl

Interface
REQ-001 Parameter addrWidth, default 8: RAM point address width.
REQ-002 Parameter centroid_num, default 8: number of centroid registers.
REQ-003 Parameter RD_LAT, default 1: RAM read latency, from ram_rd_en to data valid.
REQ-004 Parameter ACC_LAT, default 3: cycles from ram_input_reg_en to accumulator capture of the same point.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to run one classification pass.
REQ-008 num_points  input  addrWidth  point count minus 1; sampled on accepted start.
REQ-009 k  input  4  active centroid count; sampled on accepted start.
REQ-010 hold  input  1  RAM port borrowed by another requester; pauses point issue.
REQ-011 ram_addr  output  addrWidth  point read address.
REQ-012 ram_rd_en  output  1  RAM read strobe.
REQ-013 ram_input_reg_en  output  1  datapath input-register load.
REQ-014 centroid_en  output  centroid_num  per-centroid register load.
REQ-015 accum_clr  output  1  clears accumulators and counters.
REQ-016 accumulators_en  output  1  accumulator/counter update strobe.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 done  output  1  one-cycle pass-complete pulse.

Function
REQ-019 FSM states: IDLE, LOAD_CEN, STREAM, DRAIN, DONE; all outputs except the pipeline strobes decode from state only.
REQ-020 IDLE -> LOAD_CEN when start=1; start in any other state is ignored.
REQ-021 LOAD_CEN lasts exactly 1 cycle: accum_clr=1; centroid_en bits [k-1:0]=1, others 0; k=0 or k>centroid_num loads all bits.
REQ-022 LOAD_CEN -> STREAM unconditionally; address counter = 0, issued counter = 0.
REQ-023 STREAM, hold=0: ram_rd_en=1, ram_addr=address counter, then counter increments.
REQ-024 STREAM, hold=1: ram_rd_en=0, address frozen, no point issued.
REQ-025 STREAM -> DRAIN in the cycle after the read of address num_points is issued.
REQ-026 ram_input_reg_en equals ram_rd_en delayed by RD_LAT cycles; accumulators_en equals ram_input_reg_en delayed by ACC_LAT cycles; both are implemented as a valid shift register.
REQ-027 Hold bubbles propagate as deasserted strobes; the shift register is never stalled.
REQ-028 DRAIN -> DONE in the cycle after the shift register becomes empty; DONE lasts 1 cycle with done=1, then -> IDLE.
REQ-029 num_points=0 runs exactly 1 point; num_points=2^addrWidth-1 runs all addresses, with no wrap or extra read.
REQ-030 hold has no effect outside STREAM.
REQ-031 ram_addr holds its last value when ram_rd_en=0.

Reset
REQ-032 rst=1 immediately forces state IDLE and clears all counters and the valid shift register; every output reads 0, including ram_addr.
REQ-033 Reset mid-pass abandons the pass: no done pulse, and no further strobes from in-flight points.
REQ-034 After rst deasserts, the block accepts start on the first clock edge.

Structure
REQ-035 The state enum and the RD_LAT/ACC_LAT defaults live in the shared k-means package, used by the datapath and the core.
REQ-036 The valid delay line is one sub-module, valid_delay_line, parameterised by depth, with asynchronous active-high reset.
REQ-037 No arithmetic wider than addrWidth+1 bits; the issued counter is addrWidth+1 bits.

Verification
REQ-038 start at cycle 0, num_points=3, k=8, hold=0 -> centroid_en=8'hFF and accum_clr at cycle 1; ram_rd_en at cycles 2-5 with addresses 0-3; ram_input_reg_en at cycles 3-6; accumulators_en at cycles 6-9; done at cycle 10; busy at cycles 1-10.
REQ-039 As REQ-038 with hold=1 in cycle 3 only -> ram_rd_en at cycles 2,4,5,6; accumulators_en at cycles 6,8,9,10; done at cycle 11.
REQ-040 k=3 -> centroid_en=8'h07; k=0 -> 8'hFF.
REQ-041 num_points=255 -> exactly 256 reads at addresses 0-255, 256 accumulators_en pulses, 1 done.
REQ-042 rst asserted at cycle 4 of a REQ-038 run -> all outputs 0 that cycle, no later strobes or done; new start completes normally.
REQ-043 start pulsed during STREAM -> ignored; single done; read count unchanged.
